// File: rtl/fp_div_seq.sv
`default_nettype none
// ============================================================================
//  Module      : fp_div_seq
//  Description : Sequential IEEE-754 binary32 divider, fp_Z = fp_X / fp_Y.
//                Radix-2 restoring mantissa division, one quotient bit per
//                clock. Subnormal operands are flushed to zero, NaN results
//                are canonical (0x7FC00000). One operation in flight.
//
//  Ports
//    clk        : clock, rising edge active
//    rst        : asynchronous active-high reset
//    in_valid   : operands valid
//    in_ready   : operands accepted (high only while idle)
//    fp_X       : dividend
//    fp_Y       : divisor
//    r_mode     : rounding mode (000 RNE, 001 RTZ, 010 RDN, 011 RUP,
//                 100 RMM, other codes RNE)
//    out_valid  : result valid
//    out_ready  : consumer accepts result
//    fp_Z       : quotient
//    ovrf/udrf  : exponent overflow / underflow
//    div_zero   : finite nonzero divided by zero
//    zer/inf/nan: result class
//
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_div_seq #(
   parameter int QBITS = 26,   // 1 integer + 23 fraction + guard + round
   parameter int CW    = 5     // iteration counter width, 2**CW > QBITS
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] fp_X,
   input  logic [31:0] fp_Y,
   input  logic [2:0]  r_mode,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] fp_Z,
   output logic        ovrf,
   output logic        udrf,
   output logic        div_zero,
   output logic        zer,
   output logic        inf,
   output logic        nan
);

   localparam logic [31:0]    C_QNAN     = 32'h7FC0_0000;
   localparam logic [CW-1:0]  C_LAST_IT  = CW'(QBITS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CALC  = 2'd1,
      ROUND = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_next_state;

   // Working registers
   logic                r_sign;
   logic signed [9:0]   r_exp;
   logic [24:0]         r_rem;
   logic [23:0]         r_div;
   logic [QBITS-1:0]    r_q;
   logic [CW-1:0]       r_cnt;
   logic [2:0]          r_rmode;

   // Result registers
   logic                r_out_valid;
   logic [31:0]         r_z;
   logic                r_ovrf;
   logic                r_udrf;
   logic                r_div_zero;
   logic                r_zer;
   logic                r_inf;
   logic                r_nan;

   // ------------------------------------------------------------------------
   // Operand classification (exp==0 is zero regardless of fraction)
   // ------------------------------------------------------------------------
   logic                w_x_zero, w_x_inf, w_x_nan;
   logic                w_y_zero, w_y_inf, w_y_nan;
   logic                w_res_nan, w_res_inf, w_res_zer, w_res_dz;
   logic                w_special;
   logic                w_in_sign;
   logic [23:0]         w_mx, w_my;
   logic                w_adj;
   logic signed [9:0]   w_exp_in;
   logic                w_accept;
   logic                w_consume;

   assign w_x_zero  = (fp_X[30:23] == 8'h00);
   assign w_x_inf   = (fp_X[30:23] == 8'hFF) && (fp_X[22:0] == 23'd0);
   assign w_x_nan   = (fp_X[30:23] == 8'hFF) && (fp_X[22:0] != 23'd0);
   assign w_y_zero  = (fp_Y[30:23] == 8'h00);
   assign w_y_inf   = (fp_Y[30:23] == 8'hFF) && (fp_Y[22:0] == 23'd0);
   assign w_y_nan   = (fp_Y[30:23] == 8'hFF) && (fp_Y[22:0] != 23'd0);

   assign w_res_nan = w_x_nan || w_y_nan || (w_x_zero && w_y_zero) ||
                      (w_x_inf && w_y_inf);
   // finite-nonzero / zero
   assign w_res_dz  = !w_res_nan && !w_x_zero && !w_x_inf && w_y_zero;
   // inf / finite (zero included), or the divide-by-zero case
   assign w_res_inf = !w_res_nan && ((w_x_inf && !w_y_inf) || w_res_dz);
   // zero / finite-nonzero, or finite / inf
   assign w_res_zer = !w_res_nan && !w_res_inf && (w_x_zero || w_y_inf);
   assign w_special = w_res_nan || w_res_inf || w_res_zer;
   assign w_in_sign = fp_X[31] ^ fp_Y[31];

   assign w_mx      = {1'b1, fp_X[22:0]};
   assign w_my      = {1'b1, fp_Y[22:0]};
   // Pre-normalise so the first quotient bit is always the integer 1
   assign w_adj     = (w_mx < w_my);
   assign w_exp_in  = $signed({2'b00, fp_X[30:23]}) - $signed({2'b00, fp_Y[30:23]})
                    + 10'sd127 - $signed({9'd0, w_adj});

   assign w_accept  = (r_state == IDLE) && in_valid;
   assign w_consume = (r_state == DONE) && r_out_valid && out_ready;

   // ------------------------------------------------------------------------
   // Restoring division step
   // ------------------------------------------------------------------------
   logic                w_ge;
   logic [24:0]         w_rem_sub;

   assign w_ge      = (r_rem >= {1'b0, r_div});
   assign w_rem_sub = w_ge ? (r_rem - {1'b0, r_div}) : r_rem;

   // ------------------------------------------------------------------------
   // Rounding
   // ------------------------------------------------------------------------
   logic                w_lsb, w_g, w_r, w_s, w_inexact, w_inc;
   logic [24:0]         w_sum;
   logic                w_carry;
   logic [22:0]         w_frac;
   logic signed [9:0]   w_exp_rnd;
   logic                w_rnd_ovf, w_rnd_udf;

   assign w_lsb     = r_q[QBITS-24];
   assign w_g       = r_q[QBITS-25];
   assign w_r       = r_q[QBITS-26];
   assign w_s       = (r_rem != 25'd0);
   assign w_inexact = w_g | w_r | w_s;

   always_comb begin
      w_inc = 1'b0;
      case (r_rmode)
         3'b001:  w_inc = 1'b0;
         3'b010:  w_inc = r_sign & w_inexact;
         3'b011:  w_inc = !r_sign & w_inexact;
         3'b100:  w_inc = w_g;
         default: w_inc = w_g & (w_r | w_s | w_lsb);
      endcase
   end

   assign w_sum     = {1'b0, r_q[QBITS-1 -: 24]} + {24'd0, w_inc};
   assign w_carry   = w_sum[24];
   // On carry-out the significand is 10.000..0; renormalise by one place
   assign w_frac    = w_carry ? w_sum[23:1] : w_sum[22:0];
   assign w_exp_rnd = r_exp + $signed({9'd0, w_carry});
   assign w_rnd_ovf = (w_exp_rnd >= 10'sd255);
   assign w_rnd_udf = (w_exp_rnd <= 10'sd0);

   // ------------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (in_valid) w_next_state = w_special ? DONE : CALC;
         CALC:    if (r_cnt == C_LAST_IT) w_next_state = ROUND;
         ROUND:   w_next_state = DONE;
         DONE:    if (r_out_valid && out_ready) w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // Datapath
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sign      <= 1'b0;
         r_exp       <= 10'sd0;
         r_rem       <= 25'd0;
         r_div       <= 24'd0;
         r_q         <= '0;
         r_cnt       <= '0;
         r_rmode     <= 3'd0;
         r_out_valid <= 1'b0;
         r_z         <= 32'd0;
         r_ovrf      <= 1'b0;
         r_udrf      <= 1'b0;
         r_div_zero  <= 1'b0;
         r_zer       <= 1'b0;
         r_inf       <= 1'b0;
         r_nan       <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_sign  <= w_in_sign;
                  r_rmode <= r_mode;
                  r_exp   <= w_exp_in;
                  r_div   <= w_my;
                  r_rem   <= w_adj ? {w_mx, 1'b0} : {1'b0, w_mx};
                  r_q     <= '0;
                  r_cnt   <= '0;
                  if (w_res_nan) begin
                     r_z   <= C_QNAN;
                     r_nan <= 1'b1;
                  end else if (w_res_inf) begin
                     r_z        <= {w_in_sign, 8'hFF, 23'd0};
                     r_inf      <= 1'b1;
                     r_div_zero <= w_res_dz;
                  end else if (w_res_zer) begin
                     r_z   <= {w_in_sign, 31'd0};
                     r_zer <= 1'b1;
                  end
               end
            end
            CALC: begin
               r_q   <= {r_q[QBITS-2:0], w_ge};
               r_rem <= {w_rem_sub[23:0], 1'b0};
               r_cnt <= r_cnt + 1'b1;
            end
            ROUND: begin
               if (w_rnd_ovf) begin
                  r_z    <= {r_sign, 8'hFF, 23'd0};
                  r_ovrf <= 1'b1;
                  r_inf  <= 1'b1;
               end else if (w_rnd_udf) begin
                  r_z    <= {r_sign, 31'd0};
                  r_udrf <= 1'b1;
                  r_zer  <= 1'b1;
               end else begin
                  r_z    <= {r_sign, w_exp_rnd[7:0], w_frac};
               end
            end
            DONE: begin
               // out_valid follows entry into DONE by one edge
               if (w_consume) begin
                  r_out_valid <= 1'b0;
                  r_z         <= 32'd0;
                  r_ovrf      <= 1'b0;
                  r_udrf      <= 1'b0;
                  r_div_zero  <= 1'b0;
                  r_zer       <= 1'b0;
                  r_inf       <= 1'b0;
                  r_nan       <= 1'b0;
               end else begin
                  r_out_valid <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (r_state == IDLE);
   assign out_valid = r_out_valid;
   assign fp_Z      = r_z;
   assign ovrf      = r_ovrf;
   assign udrf      = r_udrf;
   assign div_zero  = r_div_zero;
   assign zer       = r_zer;
   assign inf       = r_inf;
   assign nan       = r_nan;

endmodule
`default_nettype wire

// File: tb/tb_fp_div_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_div_seq
//  Description : Self-checking bench for fp_div_seq. Directed vector table
//                plus hand-written backpressure and mid-operation reset
//                sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_div_seq;

   localparam int NV      = 26;
   localparam int TIMEOUT = 200;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] fp_X = 32'd0;
   logic [31:0] fp_Y = 32'd0;
   logic [2:0]  r_mode = 3'd0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] fp_Z;
   logic        ovrf, udrf, div_zero, zer, inf, nan;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   fp_div_seq #(.QBITS(26), .CW(5)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .fp_X      (fp_X),
      .fp_Y      (fp_Y),
      .r_mode    (r_mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .fp_Z      (fp_Z),
      .ovrf      (ovrf),
      .udrf      (udrf),
      .div_zero  (div_zero),
      .zer       (zer),
      .inf       (inf),
      .nan       (nan)
   );

   // flags packed as {ovrf, udrf, div_zero, zer, inf, nan}
   typedef struct {
      logic [31:0] x;
      logic [31:0] y;
      logic [2:0]  m;
      logic [31:0] z;
      logic [5:0]  f;
      int          lat;
   } vec_t;

   vec_t vecs [NV];

   function automatic logic [5:0] flags();
      return {ovrf, udrf, div_zero, zer, inf, nan};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp_v);
      end
   endtask

   // Wait for out_valid, counting edges since the accepting edge; in_ready
   // must stay low meanwhile. Called at #1 after the accepting edge.
   task automatic wait_result(input string nm, output int lat);
      logic busy_ok;
      busy_ok = 1'b1;
      lat = 0;
      while (!out_valid && lat < TIMEOUT) begin
         if (in_ready) busy_ok = 1'b0;
         @(posedge clk); #1;
         lat++;
      end
      if (lat >= TIMEOUT) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s timeout: out_valid not seen within %0d edges", nm, TIMEOUT);
      end
      chk({nm, " in_ready_busy"}, {31'd0, busy_ok}, 32'd1);
   endtask

   task automatic consume(input string nm);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({nm, " out_valid_after_consume"}, {31'd0, out_valid}, 32'd0);
      chk({nm, " in_ready_after_consume"}, {31'd0, in_ready}, 32'd1);
      chk({nm, " flags_cleared"}, {26'd0, flags()}, 32'd0);
   endtask

   task automatic run_op(input string nm, input logic [31:0] x, input logic [31:0] y,
                         input logic [2:0] m, input logic [31:0] ez,
                         input logic [5:0] ef, input int elat);
      int lat;
      chk({nm, " in_ready_idle"}, {31'd0, in_ready}, 32'd1);
      fp_X = x; fp_Y = y; r_mode = m; in_valid = 1'b1;
      @(posedge clk); #1;
      // Disturb inputs after accept: only the latched copies may matter
      in_valid = 1'b0;
      fp_X     = ~x;
      fp_Y     = y ^ 32'h0055_AA00;
      r_mode   = m ^ 3'b010;
      wait_result(nm, lat);
      chk({nm, " latency"}, lat, elat);
      chk({nm, " fp_Z"}, fp_Z, ez);
      chk({nm, " flags"}, {26'd0, flags()}, {26'd0, ef});
      consume(nm);
   endtask

   initial begin
      int lat;
      logic stable_ok;
      logic [31:0] held_z;
      logic [5:0]  held_f;

      vecs[ 0] = '{32'h40C00000, 32'h40000000, 3'd0, 32'h40400000, 6'b000000, 28};
      vecs[ 1] = '{32'h3F800000, 32'h40400000, 3'd0, 32'h3EAAAAAB, 6'b000000, 28};
      vecs[ 2] = '{32'h3F800000, 32'h40400000, 3'd1, 32'h3EAAAAAA, 6'b000000, 28};
      vecs[ 3] = '{32'h3F800000, 32'h40400000, 3'd3, 32'h3EAAAAAB, 6'b000000, 28};
      vecs[ 4] = '{32'h3F800000, 32'h40400000, 3'd2, 32'h3EAAAAAA, 6'b000000, 28};
      vecs[ 5] = '{32'hBF800000, 32'h40400000, 3'd2, 32'hBEAAAAAB, 6'b000000, 28};
      vecs[ 6] = '{32'hBF800000, 32'h40400000, 3'd3, 32'hBEAAAAAA, 6'b000000, 28};
      vecs[ 7] = '{32'h3F800000, 32'h40400000, 3'd4, 32'h3EAAAAAB, 6'b000000, 28};
      vecs[ 8] = '{32'h3F800000, 32'h40400000, 3'd7, 32'h3EAAAAAB, 6'b000000, 28};
      vecs[ 9] = '{32'hBF800000, 32'h40400000, 3'd1, 32'hBEAAAAAA, 6'b000000, 28};
      vecs[10] = '{32'hC0C00000, 32'h40000000, 3'd0, 32'hC0400000, 6'b000000, 28};
      vecs[11] = '{32'h3F800000, 32'h3F800000, 3'd0, 32'h3F800000, 6'b000000, 28};
      vecs[12] = '{32'h3FC00000, 32'h3F400000, 3'd0, 32'h40000000, 6'b000000, 28};
      vecs[13] = '{32'h3F800000, 32'h00000000, 3'd0, 32'h7F800000, 6'b001010, 1};
      vecs[14] = '{32'h00000000, 32'h00000000, 3'd0, 32'h7FC00000, 6'b000001, 1};
      vecs[15] = '{32'h7F800000, 32'h7F800000, 3'd0, 32'h7FC00000, 6'b000001, 1};
      vecs[16] = '{32'h00400000, 32'h3F800000, 3'd0, 32'h00000000, 6'b000100, 1};
      vecs[17] = '{32'h7FC00001, 32'h3F800000, 3'd0, 32'h7FC00000, 6'b000001, 1};
      vecs[18] = '{32'hBF800000, 32'h00000000, 3'd0, 32'hFF800000, 6'b001010, 1};
      vecs[19] = '{32'h7F800000, 32'hC0000000, 3'd0, 32'hFF800000, 6'b000010, 1};
      vecs[20] = '{32'h40000000, 32'hFF800000, 3'd0, 32'h80000000, 6'b000100, 1};
      vecs[21] = '{32'h7F800000, 32'h00000000, 3'd0, 32'h7F800000, 6'b000010, 1};
      vecs[22] = '{32'h3F800000, 32'h7F800000, 3'd0, 32'h00000000, 6'b000100, 1};
      vecs[23] = '{32'h7F000000, 32'h3E800000, 3'd0, 32'h7F800000, 6'b100010, 28};
      vecs[24] = '{32'h00800000, 32'h40000000, 3'd0, 32'h00000000, 6'b010100, 28};
      vecs[25] = '{32'hFF000000, 32'h3E800000, 3'd1, 32'hFF800000, 6'b100010, 28};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("reset out_valid", {31'd0, out_valid}, 32'd0);
      chk("reset fp_Z", fp_Z, 32'd0);
      chk("reset flags", {26'd0, flags()}, 32'd0);
      chk("reset in_ready", {31'd0, in_ready}, 32'd1);
      rst = 1'b0;
      @(posedge clk); #1;

      // Directed table
      for (int i = 0; i < NV; i++) begin
         run_op($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].m,
                vecs[i].z, vecs[i].f, vecs[i].lat);
      end

      // Backpressure: result held, inputs ignored, then release
      fp_X = 32'h40C00000; fp_Y = 32'h40000000; r_mode = 3'd0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_result("bp", lat);
      chk("bp latency", lat, 28);
      held_z    = fp_Z;
      held_f    = flags();
      stable_ok = 1'b1;
      fp_X = 32'h41200000; fp_Y = 32'h40A00000; in_valid = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         if (!out_valid || fp_Z !== held_z || flags() !== held_f || in_ready)
            stable_ok = 1'b0;
      end
      chk("bp held fp_Z", held_z, 32'h40400000);
      chk("bp stable", {31'd0, stable_ok}, 32'd1);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("bp out_valid_released", {31'd0, out_valid}, 32'd0);
      chk("bp in_ready_released", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;   // in_valid still high: accepted here
      in_valid = 1'b0;
      chk("bp reaccepted", {31'd0, in_ready}, 32'd0);
      wait_result("bp2", lat);
      chk("bp2 latency", lat, 28);
      chk("bp2 fp_Z", fp_Z, 32'h40000000);
      consume("bp2");

      // Reset during CALC iteration 10
      fp_X = 32'h40C00000; fp_Y = 32'h40000000; r_mode = 3'd0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("rst_mid out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_mid fp_Z", fp_Z, 32'd0);
      chk("rst_mid flags", {26'd0, flags()}, 32'd0);
      chk("rst_mid in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      chk("rst_after out_valid", {31'd0, out_valid}, 32'd0);
      run_op("post_rst", 32'h41200000, 32'h40A00000, 3'd0, 32'h40000000, 6'b000000, 28);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Absolute watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
`default_nettype wire
